ram_port_arbiter: RTL and testbench

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

---
 rtl/ram_arb_pkg.sv | 15 +
 rtl/ram_port_arbiter_rr.sv | 30 +++
 rtl/ram_port_arbiter.sv | 122 ++++++++++++
 tb/tb_ram_port_arbiter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types and default sizing for the RAM port arbiter.
package ram_arb_pkg;

   typedef enum logic {
      IDLE    = 1'b0,
      GRANTED = 1'b1
   } state_t;

   localparam int DEF_NUM_REQ    = 2;
   localparam int DEF_ADDR_WIDTH = 16;
   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_BYTE_WIDTH = 8;
   localparam int DEF_MAX_BURST  = 256;

endpackage

// File: rtl/ram_port_arbiter_rr.sv
// Combinational round-robin picker: first active request at or after ptr, wrapping.
module rr_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   grant_idx,
   output logic               any
);

   always_comb begin
      int j;
      grant     = '0;
      grant_idx = '0;
      any       = 1'b0;
      j         = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         j = int'(ptr) + i;
         if (j >= NUM_REQ) j = j - NUM_REQ;
         if (!any && req[j]) begin
            any       = 1'b1;
            grant[j]  = 1'b1;
            grant_idx = IDX_W'(j);
         end
      end
   end

endmodule

// File: rtl/ram_port_arbiter.sv
// Single-port RAM arbiter: round-robin grant, burst lock until last beat or
// MAX_BURST beats, 1-cycle read response routed to the requester that issued it.
module ram_port_arbiter
   import ram_arb_pkg::*;
#(
   parameter int NUM_REQ     = DEF_NUM_REQ,
   parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int BYTE_WIDTH  = DEF_BYTE_WIDTH,
   parameter int BATCH_WIDTH = DATA_WIDTH / BYTE_WIDTH,
   parameter int MAX_BURST   = DEF_MAX_BURST
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic [NUM_REQ-1:0]                    req_valid,
   output logic [NUM_REQ-1:0]                    req_ready,
   input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]    req_addr,
   input  logic [NUM_REQ-1:0]                    req_write,
   input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]    req_wdata,
   input  logic [NUM_REQ-1:0][BATCH_WIDTH-1:0]   req_byte_en,
   input  logic [NUM_REQ-1:0]                    req_last,
   output logic [NUM_REQ-1:0]                    rsp_valid,
   output logic [DATA_WIDTH-1:0]                 rsp_data,
   output logic [ADDR_WIDTH-1:0]                 addr,
   output logic [DATA_WIDTH-1:0]                 write,
   output logic                                  write_en,
   output logic [BATCH_WIDTH-1:0]                byte_en,
   input  logic [DATA_WIDTH-1:0]                 data
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = $clog2(MAX_BURST) + 1;

   state_t             state, state_nxt;
   logic [IDX_W-1:0]   owner, owner_nxt;
   logic [IDX_W-1:0]   rr_ptr, rr_nxt;
   logic [CNT_W-1:0]   beat_cnt, cnt_nxt;
   logic               rd_pend;
   logic [IDX_W-1:0]   rsp_idx;
   logic               accept;

   logic [NUM_REQ-1:0] arb_grant;
   logic [IDX_W-1:0]   arb_idx;
   logic               arb_any;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr (
      .req       (req_valid),
      .ptr       (rr_ptr),
      .grant     (arb_grant),
      .grant_idx (arb_idx),
      .any       (arb_any)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         owner    <= '0;
         rr_ptr   <= '0;
         beat_cnt <= '0;
         rd_pend  <= 1'b0;
         rsp_idx  <= '0;
      end else begin
         state    <= state_nxt;
         owner    <= owner_nxt;
         rr_ptr   <= rr_nxt;
         beat_cnt <= cnt_nxt;
         // Response index is captured per beat so a handoff cannot misroute it.
         rd_pend  <= accept && !req_write[owner];
         rsp_idx  <= owner;
      end
   end

   always_comb begin
      state_nxt = state;
      owner_nxt = owner;
      rr_nxt    = rr_ptr;
      cnt_nxt   = beat_cnt;
      req_ready = '0;
      addr      = '0;
      write     = '0;
      write_en  = 1'b0;
      byte_en   = '0;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            if (arb_any) begin
               owner_nxt = arb_idx;
               cnt_nxt   = '0;
               state_nxt = GRANTED;
            end
         end
         GRANTED: begin
            req_ready[owner] = 1'b1;
            addr             = req_addr[owner];
            write            = req_wdata[owner];
            accept           = req_valid[owner];
            if (accept) begin
               cnt_nxt = beat_cnt + 1'b1;
               if (req_write[owner]) begin
                  write_en = 1'b1;
                  byte_en  = req_byte_en[owner];
               end
               if (req_last[owner] || beat_cnt == CNT_W'(MAX_BURST - 1)) begin
                  state_nxt = IDLE;
                  rr_nxt    = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
               end
            end
         end
      endcase
   end

   always_comb begin
      rsp_valid = '0;
      if (rd_pend) rsp_valid[rsp_idx] = 1'b1;
   end

   assign rsp_data = data;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a 1-cycle-latency byte-enabled RAM model.
module tb_ram_port_arbiter;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [1:0]        req_valid, req_ready, req_write, req_last, rsp_valid;
   logic [1:0][15:0]  req_addr;
   logic [1:0][31:0]  req_wdata;
   logic [1:0][3:0]   req_byte_en;
   logic [31:0]       rsp_data, write, data;
   logic [15:0]       addr;
   logic              write_en;
   logic [3:0]        byte_en;

   int pass_cnt = 0;
   int total_cnt = 0;

   logic [31:0] mem     [0:65535];
   bit          wr_flag [0:65535];

   always #5 clk = ~clk;

   ram_port_arbiter dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_addr    (req_addr),
      .req_write   (req_write),
      .req_wdata   (req_wdata),
      .req_byte_en (req_byte_en),
      .req_last    (req_last),
      .rsp_valid   (rsp_valid),
      .rsp_data    (rsp_data),
      .addr        (addr),
      .write       (write),
      .write_en    (write_en),
      .byte_en     (byte_en),
      .data        (data)
   );

   // Unwritten locations read back a fixed address-derived pattern.
   function automatic logic [31:0] pat(input logic [15:0] a);
      if (a == 16'h0010) return 32'hDEADBEEF;
      return {~a, a};
   endfunction

   always @(posedge clk) begin
      if (write_en) begin
         for (int b = 0; b < 4; b++)
            if (byte_en[b]) mem[addr][b*8 +: 8] <= write[b*8 +: 8];
         wr_flag[addr] <= 1'b1;
      end
      data <= wr_flag[addr] ? mem[addr] : pat(addr);
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic set_req(input int r, input logic v, input logic w, input logic [15:0] a,
                          input logic [31:0] d, input logic [3:0] be, input logic l);
      req_valid[r]   = v;
      req_write[r]   = w;
      req_addr[r]    = a;
      req_wdata[r]   = d;
      req_byte_en[r] = be;
      req_last[r]    = l;
   endtask

   initial begin
      int acc, rsp;
      bit seen1;
      rst_n = 1'b0;
      req_valid = '0; req_write = '0; req_last = '0;
      req_addr = '0; req_wdata = '0; req_byte_en = '0;
      tick; tick;
      chk("rst_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_write_en", write_en, 0);
      chk("rst_byte_en", byte_en, 0);
      chk("rst_addr", addr, 0);
      rst_n = 1'b1;

      // single read
      set_req(0, 1, 0, 16'h0010, 0, 4'h0, 1);
      #1 chk("t1_idle_ready", req_ready, 2'b00);
      tick;
      chk("t1_grant", req_ready, 2'b01);
      chk("t1_addr", addr, 16'h0010);
      chk("t1_write_en", write_en, 0);
      tick;
      req_valid = '0;
      #1;
      chk("t1_rsp_valid", rsp_valid, 2'b01);
      chk("t1_rsp_data", rsp_data, 32'hDEADBEEF);
      chk("t1_idle_after", req_ready, 2'b00);
      tick;
      chk("t1_rsp_done", rsp_valid, 2'b00);

      // contention from reset: alternation
      rst_n = 1'b0; #1; rst_n = 1'b1;
      set_req(0, 1, 1, 16'h0200, 32'hAAAA0000, 4'hF, 1);
      set_req(1, 1, 1, 16'h0201, 32'hBBBB1111, 4'hF, 1);
      #1 chk("t2_idle_ready", req_ready, 2'b00);
      tick;
      chk("t2_first_r0", req_ready, 2'b01);
      chk("t2_write_en", write_en, 1);
      chk("t2_addr", addr, 16'h0200);
      chk("t2_wdata", write, 32'hAAAA0000);
      chk("t2_byte_en", byte_en, 4'hF);
      tick;
      chk("t2_idle1", req_ready, 2'b00);
      tick;
      chk("t2_second_r1", req_ready, 2'b10);
      chk("t2_addr1", addr, 16'h0201);
      tick;
      chk("t2_idle2", req_ready, 2'b00);
      tick;
      chk("t2_third_r0", req_ready, 2'b01);
      tick;
      req_valid = '0;
      tick;
      chk("t2_mem200", mem[16'h0200], 32'hAAAA0000);
      chk("t2_mem201", mem[16'h0201], 32'hBBBB1111);

      // burst lock: requester 1 writes 4 beats while 0 waits
      set_req(0, 1, 0, 16'h0030, 0, 4'h0, 1);
      set_req(1, 1, 1, 16'h0100, 1, 4'hF, 0);
      tick;
      for (int k = 1; k <= 4; k++) begin
         if (k == 3) begin
            req_valid[1] = 1'b0;
            #1;
            chk("t3_lock_hold", req_ready, 2'b10);
            chk("t3_bubble_we", write_en, 0);
            chk("t3_bubble_be", byte_en, 4'h0);
            tick;
            req_valid[1] = 1'b1;
         end
         req_addr[1]  = 16'h0100 + 16'(k - 1);
         req_wdata[1] = 32'(k);
         req_last[1]  = (k == 4);
         #1;
         chk($sformatf("t3_ready_b%0d", k), req_ready, 2'b10);
         chk($sformatf("t3_we_b%0d", k), write_en, 1);
         tick;
      end
      req_valid[1] = 1'b0;
      #1 chk("t3_idle", req_ready, 2'b00);
      tick;
      chk("t3_r0_after", req_ready, 2'b01);
      tick;
      req_valid = '0;
      #1;
      chk("t3_rsp_valid", rsp_valid, 2'b01);
      chk("t3_rsp_data", rsp_data, pat(16'h0030));
      for (int k = 1; k <= 4; k++)
         chk($sformatf("t3_mem_%0d", k), mem[16'h0100 + 16'(k - 1)], 64'(k));
      tick;

      // MAX_BURST cap with requester 1 pending
      set_req(0, 1, 0, 16'h1000, 0, 4'h0, 0);
      tick;
      set_req(1, 1, 0, 16'h0040, 0, 4'h0, 1);
      acc = 0; rsp = 0; seen1 = 0;
      for (int c = 0; c < 400 && !seen1; c++) begin
         req_addr[0] = 16'h1000 + 16'(acc);
         #1;
         if (req_ready[1]) begin
            seen1 = 1;
            chk("t4_handoff_ready", req_ready, 2'b10);
            chk("t4_no_overlap", rsp_valid, 2'b00);
         end else begin
            if (rsp_valid[0]) begin
               chk("t4_rsp_data", rsp_data, pat(16'h1000 + 16'(rsp)));
               rsp++;
            end
            if (req_ready[0] && req_valid[0]) acc++;
            tick;
         end
      end
      chk("t4_r1_granted", seen1, 1);
      chk("t4_beats", acc, 256);
      chk("t4_rsp_count", rsp, 256);
      tick;
      req_valid = '0;
      #1;
      chk("t4_r1_rsp", rsp_valid, 2'b10);
      chk("t4_r1_data", rsp_data, pat(16'h0040));
      tick;

      // handoff response delivered in IDLE, no overlap
      set_req(0, 1, 0, 16'h0020, 0, 4'h0, 1);
      set_req(1, 1, 0, 16'h0040, 0, 4'h0, 1);
      tick;
      chk("t5_r0", req_ready, 2'b01);
      tick;
      chk("t5_rsp0", rsp_valid, 2'b01);
      chk("t5_rsp0_data", rsp_data, pat(16'h0020));
      chk("t5_idle", req_ready, 2'b00);
      tick;
      chk("t5_r1", req_ready, 2'b10);
      chk("t5_no_overlap", rsp_valid, 2'b00);
      tick;
      req_valid = '0;
      #1;
      chk("t5_rsp1", rsp_valid, 2'b10);
      chk("t5_rsp1_data", rsp_data, pat(16'h0040));
      tick;

      // reset during beat 2 of a 4-beat burst by requester 1
      set_req(1, 1, 0, 16'h0050, 0, 4'hF, 0);
      tick;
      chk("t6_r1", req_ready, 2'b10);
      tick;
      set_req(1, 1, 1, 16'h0051, 32'h77, 4'hF, 0);
      #1;
      chk("t6_pre_ready", req_ready, 2'b10);
      chk("t6_pre_rsp", rsp_valid, 2'b10);
      chk("t6_pre_we", write_en, 1);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_ready", req_ready, 2'b00);
      chk("t6_rst_we", write_en, 0);
      chk("t6_rst_rsp", rsp_valid, 2'b00);
      chk("t6_rst_be", byte_en, 4'h0);
      tick;
      chk("t6_rst_rsp_hold", rsp_valid, 2'b00);
      rst_n = 1'b1;
      set_req(0, 1, 0, 16'h0060, 0, 4'h0, 1);
      #1 chk("t6_idle", req_ready, 2'b00);
      tick;
      chk("t6_first_r0", req_ready, 2'b01);
      tick;
      req_valid = '0;
      #1 chk("t6_rsp0", rsp_valid, 2'b01);
      tick;

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
